hw_acc_cm_tag_alloc: RTL and testbench
======================================

HW_ACC_CM_TAG_ALLOC -- requirements
Module: hw_acc_cm_tag_alloc

Interface
REQ-001 SHALL have parameter TAG_NUM, default 32, number of request tags shared by context-fetch threads.
REQ-002 SHALL have parameter TAG_NUM_LOG, default 5, tag width, log2(TAG_NUM).
REQ-003 SHALL have port clk, input, 1, single clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tag_alloc_valid, output, 1, a free tag is offered.
REQ-006 SHALL have port tag_alloc_tag, output, TAG_NUM_LOG, offered tag.
REQ-007 SHALL have port tag_alloc_ready, input, 1, requester takes the offered tag.
REQ-008 SHALL have port tag_release_valid, input, 1, combine stage returns a tag.
REQ-009 SHALL have port tag_release_tag, input, TAG_NUM_LOG, returned tag.
REQ-010 SHALL have port tag_release_ready, output, 1, release accepted.
REQ-011 SHALL have port busy_cnt, output, TAG_NUM_LOG+1, number of tags outstanding.
REQ-012 SHALL have port err_dbl_release, output, 1, one-cycle pulse on release of a non-busy tag.

Function
REQ-013 SHALL hold a free-list FIFO of depth TAG_NUM with read ptr, write ptr (TAG_NUM_LOG bits, natural wrap) and free count (TAG_NUM_LOG+1 bits), plus a TAG_NUM-bit busy bitmap.
REQ-014 SHALL implement states INIT_s and RUN_s; INIT_s -> RUN_s after TAG_NUM init cycles; RUN_s persists until reset.
REQ-015 In INIT_s SHALL write tag k to free-list entry k on init cycle k (k = 0..TAG_NUM-1), ending with free count = TAG_NUM, write ptr wrapped to 0, bitmap all zero.
REQ-016 SHALL keep tag_alloc_valid = 0 and tag_release_ready = 0 throughout INIT_s.
REQ-017 In RUN_s SHALL drive tag_alloc_valid = (free count != 0) and tag_alloc_tag = free-list[read ptr], both from registers only.
REQ-018 Allocation fires on tag_alloc_valid && tag_alloc_ready: read ptr +1, free count -1, bitmap[tag] set, all at the next edge.
REQ-019 SHALL hold tag_alloc_tag stable while tag_alloc_valid is high and ready is low.
REQ-020 In RUN_s SHALL drive tag_release_ready = 1 unconditionally.
REQ-021 Release fires on tag_release_valid && tag_release_ready with bitmap[tag] = 1: tag written at write ptr, write ptr +1, free count +1, bitmap[tag] cleared.
REQ-022 Release of a tag with bitmap[tag] = 0 SHALL be dropped (no pointer/count/bitmap change) and SHALL pulse err_dbl_release for exactly one cycle on the following cycle.
REQ-023 Simultaneous alloc and valid release SHALL advance both pointers and leave free count unchanged; releasing the tag being allocated in that same cycle counts as a non-busy release (REQ-022).
REQ-024 A released tag SHALL be offerable no earlier than the cycle after the release edge; at free count 0 a release makes tag_alloc_valid high on the next cycle.
REQ-025 Tags SHALL be issued in FIFO order (initially 0,1,2,...; then in release order).
REQ-026 busy_cnt SHALL equal TAG_NUM - free count, registered; it is 0 in INIT_s.
REQ-027 Free count SHALL never exceed TAG_NUM or go below 0 under any input sequence.

Reset
REQ-028 On rst_n low, asynchronously: state INIT_s, init counter 0, pointers 0, free count 0, bitmap 0, all outputs 0.
REQ-029 Reset asserted mid-operation SHALL discard all outstanding tags; after release INIT_s reruns fully (TAG_NUM cycles) before any alloc.
REQ-030 First tag_alloc_valid SHALL rise at clock edge TAG_NUM+1 counted from the first edge with rst_n high.

Structure
REQ-031 SHALL take TAG_NUM default from `MAX_REQ_TAG_NUM in protocol_engine_def.vh; state encodings local parameters.
REQ-032 SHALL be one module; free list a register array (no RAM sub-module, no FIFO IP).

Verification
REQ-033 Reset release, ready=1 held -> alloc_valid low 32 cycles, then tags 0..31 on consecutive cycles, then alloc_valid=0, busy_cnt=32.
REQ-034 All allocated; release 7 then 3 -> next allocs return 7 then 3; busy_cnt 32->30->32.
REQ-035 Free count 5, alloc of tag X and release of busy tag 12 same cycle -> free count stays 5, bitmap[X]=1, bitmap[12]=0.
REQ-036 Release tag 9 twice (busy once) -> first accepted, second dropped, err_dbl_release high exactly one cycle, busy_cnt decremented once.
REQ-037 ready=0 with alloc_valid high for 10 cycles -> tag_alloc_tag constant, busy_cnt constant.
REQ-038 rst_n low mid-run with 20 tags busy -> outputs 0 immediately; after release, 32 INIT cycles, tags reissued from 0, busy_cnt=0.

Source files
------------

// File: rtl/hw_acc_cm_tag_alloc_pkg.sv
// Shared definitions for the context-fetch request tag allocator.
//   MAX_REQ_TAG_NUM     : number of request tags in the protocol engine
//   MAX_REQ_TAG_NUM_LOG : log2(MAX_REQ_TAG_NUM)
//   tag_alloc_state_e   : allocator FSM states
package hw_acc_cm_tag_alloc_pkg;

  localparam int unsigned MAX_REQ_TAG_NUM     = 32;
  localparam int unsigned MAX_REQ_TAG_NUM_LOG = 5;

  typedef enum logic {
    INIT_s = 1'b0,
    RUN_s  = 1'b1
  } tag_alloc_state_e;

endpackage

// File: rtl/hw_acc_cm_tag_alloc.sv
// Request tag allocator shared by the context-fetch threads.
// Free tags live in a circular free list; a busy bitmap guards against double release.
// After reset the free list is filled with tags 0..TAG_NUM-1, one per cycle.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   tag_alloc_valid/_tag  : registered offer of the tag at the head of the free list
//   tag_alloc_ready       : requester takes the offered tag
//   tag_release_valid/_tag: combine stage returns a tag
//   tag_release_ready     : high once initialisation is done
//   busy_cnt              : number of tags outstanding (registered)
//   err_dbl_release       : one-cycle pulse after a release of a non-busy tag
module hw_acc_cm_tag_alloc
  import hw_acc_cm_tag_alloc_pkg::*;
#(
  parameter int unsigned TAG_NUM     = MAX_REQ_TAG_NUM,
  parameter int unsigned TAG_NUM_LOG = MAX_REQ_TAG_NUM_LOG
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   tag_alloc_valid,
  output logic [TAG_NUM_LOG-1:0] tag_alloc_tag,
  input  logic                   tag_alloc_ready,
  input  logic                   tag_release_valid,
  input  logic [TAG_NUM_LOG-1:0] tag_release_tag,
  output logic                   tag_release_ready,
  output logic [TAG_NUM_LOG:0]   busy_cnt,
  output logic                   err_dbl_release
);

  localparam logic [TAG_NUM_LOG:0]   TagNumW = (TAG_NUM_LOG + 1)'(TAG_NUM);
  localparam logic [TAG_NUM_LOG-1:0] LastTag = TAG_NUM_LOG'(TAG_NUM - 1);

  tag_alloc_state_e state_q, state_d;

  logic [TAG_NUM_LOG-1:0] init_cnt_q, init_cnt_d;
  logic [TAG_NUM_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_NUM_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_NUM_LOG:0]   free_cnt_q, free_cnt_d;
  logic [TAG_NUM-1:0]     bitmap_q, bitmap_d;

  logic                   valid_q, valid_d;
  logic [TAG_NUM_LOG-1:0] tag_q, tag_d;
  logic [TAG_NUM_LOG:0]   busy_q, busy_d;
  logic                   err_q, err_d;

  logic [TAG_NUM_LOG-1:0] free_list_q [TAG_NUM];
  logic                   fl_we;
  logic [TAG_NUM_LOG-1:0] fl_wdata;

  logic alloc_fire, rel_fire, rel_bad;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    free_cnt_d = free_cnt_q;
    bitmap_d   = bitmap_q;
    fl_we      = 1'b0;
    fl_wdata   = '0;
    alloc_fire = 1'b0;
    rel_fire   = 1'b0;
    rel_bad    = 1'b0;

    unique case (state_q)
      INIT_s: begin
        fl_we      = 1'b1;
        fl_wdata   = init_cnt_q;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        free_cnt_d = free_cnt_q + 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastTag) begin
          state_d = RUN_s;
        end
      end
      RUN_s: begin
        alloc_fire = valid_q && tag_alloc_ready;
        // The bitmap is sampled before this cycle's allocation sets its bit, so
        // returning the tag being handed out right now is treated as a bad release.
        rel_fire   = tag_release_valid && bitmap_q[tag_release_tag];
        rel_bad    = tag_release_valid && !bitmap_q[tag_release_tag];
        if (rel_fire) begin
          fl_we                     = 1'b1;
          fl_wdata                  = tag_release_tag;
          wr_ptr_d                  = wr_ptr_q + 1'b1;
          bitmap_d[tag_release_tag] = 1'b0;
        end
        if (alloc_fire) begin
          rd_ptr_d          = rd_ptr_q + 1'b1;
          bitmap_d[tag_q]   = 1'b1;
        end
        if (alloc_fire && !rel_fire) begin
          free_cnt_d = free_cnt_q - 1'b1;
        end else if (rel_fire && !alloc_fire) begin
          free_cnt_d = free_cnt_q + 1'b1;
        end
      end
      default: state_d = INIT_s;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the pointers.
  always_comb begin
    valid_d = 1'b0;
    tag_d   = '0;
    busy_d  = '0;
    err_d   = rel_bad;
    if (state_q == RUN_s) begin
      valid_d = (free_cnt_d != '0);
      busy_d  = TagNumW - free_cnt_d;
      // Bypass the free list when the entry being written is the new head.
      if (rel_fire && (wr_ptr_q == rd_ptr_d)) begin
        tag_d = tag_release_tag;
      end else begin
        tag_d = free_list_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_s;
      init_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      free_cnt_q <= '0;
      bitmap_q   <= '0;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      free_cnt_q <= free_cnt_d;
      bitmap_q   <= bitmap_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Free list contents need no reset: the init pass rewrites every entry.
  always_ff @(posedge clk) begin
    if (fl_we) begin
      free_list_q[wr_ptr_q] <= fl_wdata;
    end
  end

  assign tag_alloc_valid   = valid_q;
  assign tag_alloc_tag     = tag_q;
  assign tag_release_ready = (state_q == RUN_s);
  assign busy_cnt          = busy_q;
  assign err_dbl_release   = err_q;

endmodule

// File: tb/tb_hw_acc_cm_tag_alloc.sv
// Self-checking bench for hw_acc_cm_tag_alloc: directed scenarios followed by random
// traffic, every cycle compared against a free-tag queue / busy-set reference model.
module tb_hw_acc_cm_tag_alloc;

  localparam int TAG_NUM     = 32;
  localparam int TAG_NUM_LOG = 5;

  logic                   clk;
  logic                   rst_n;
  logic                   tag_alloc_valid;
  logic [TAG_NUM_LOG-1:0] tag_alloc_tag;
  logic                   tag_alloc_ready;
  logic                   tag_release_valid;
  logic [TAG_NUM_LOG-1:0] tag_release_tag;
  logic                   tag_release_ready;
  logic [TAG_NUM_LOG:0]   busy_cnt;
  logic                   err_dbl_release;

  hw_acc_cm_tag_alloc #(
    .TAG_NUM     (TAG_NUM),
    .TAG_NUM_LOG (TAG_NUM_LOG)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tag_alloc_valid   (tag_alloc_valid),
    .tag_alloc_tag     (tag_alloc_tag),
    .tag_alloc_ready   (tag_alloc_ready),
    .tag_release_valid (tag_release_valid),
    .tag_release_tag   (tag_release_tag),
    .tag_release_ready (tag_release_ready),
    .busy_cnt          (busy_cnt),
    .err_dbl_release   (err_dbl_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of free tags in issue order, set of busy tags,
  // number of clock edges seen since reset release.
  int fq[$];
  bit busy[TAG_NUM];
  int edges;
  bit exp_err;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    for (int i = 0; i < TAG_NUM; i++) busy[i] = 1'b0;
    edges   = 0;
    exp_err = 1'b0;
  endtask

  task automatic model_edge();
    bit pre_ready;
    bit pre_valid;
    bit rel_ok;
    int t;
    pre_ready = (edges >= TAG_NUM);
    pre_valid = (edges > TAG_NUM) && (fq.size() > 0);
    exp_err   = 1'b0;
    edges++;
    if (!pre_ready) begin
      if (edges == TAG_NUM) begin
        for (int k = 0; k < TAG_NUM; k++) fq.push_back(k);
      end
    end else begin
      rel_ok  = tag_release_valid && busy[tag_release_tag];
      exp_err = tag_release_valid && !busy[tag_release_tag];
      if (pre_valid && tag_alloc_ready) begin
        t       = fq.pop_front();
        busy[t] = 1'b1;
      end
      if (rel_ok) begin
        busy[tag_release_tag] = 1'b0;
        fq.push_back(int'(tag_release_tag));
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (edges > TAG_NUM) && (fq.size() > 0);
    check("alloc_valid", 32'(tag_alloc_valid), 32'(exp_valid));
    if (exp_valid) check("alloc_tag", 32'(tag_alloc_tag), fq[0]);
    check("release_ready", 32'(tag_release_ready), 32'(edges >= TAG_NUM));
    check("busy_cnt", 32'(busy_cnt), (edges >= TAG_NUM) ? TAG_NUM - fq.size() : 0);
    check("err_dbl_release", 32'(err_dbl_release), 32'(exp_err));
  endtask

  // One clock: update the model at the edge, compare #1 later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    check_outputs();
  endtask

  task automatic rel(input int t);
    tag_release_valid = 1'b1;
    tag_release_tag   = TAG_NUM_LOG'(t);
    step();
    tag_release_valid = 1'b0;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    tag_release_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int busy_list[$];
    rst_n             = 1'b0;
    tag_alloc_ready   = 1'b0;
    tag_release_valid = 1'b0;
    tag_release_tag   = '0;
    model_reset();
    #2;
    check_outputs();
    repeat (3) step();
    #2;
    rst_n = 1'b1;

    // Init pass, then tags 0..31 back to back with ready held high.
    tag_alloc_ready = 1'b1;
    repeat (TAG_NUM * 2 + 3) step();
    check("all_busy", 32'(busy_cnt), TAG_NUM);

    // Release 7 then 3, then reallocate in that order.
    tag_alloc_ready = 1'b0;
    rel(7);
    rel(3);
    step();
    tag_alloc_ready = 1'b1;
    repeat (3) step();
    tag_alloc_ready = 1'b0;

    // Double release of tag 9.
    rel(9);
    rel(9);
    repeat (2) step();

    // Offer held while ready is low.
    rel(20);
    rel(21);
    repeat (10) step();
    tag_alloc_ready = 1'b1;
    repeat (4) step();
    tag_alloc_ready = 1'b0;

    // Five free, then alloc and release of busy tag 12 in the same cycle.
    rel(1);
    rel(2);
    rel(4);
    rel(5);
    rel(6);
    step();
    check("free5_busy", 32'(busy_cnt), TAG_NUM - 5);
    tag_alloc_ready = 1'b1;
    rel(12);
    tag_alloc_ready = 1'b0;
    step();
    check("simul_busy", 32'(busy_cnt), TAG_NUM - 5);

    // Release of the tag being allocated in the same cycle.
    tag_alloc_ready = 1'b1;
    rel(fq[0]);
    tag_alloc_ready = 1'b0;
    step();

    // Random traffic, mostly releasing busy tags.
    repeat (1500) begin
      tag_alloc_ready   = ($urandom_range(0, 3) != 0);
      tag_release_valid = $urandom_range(0, 1) == 1;
      busy_list.delete();
      for (int i = 0; i < TAG_NUM; i++) if (busy[i]) busy_list.push_back(i);
      if (busy_list.size() > 0 && $urandom_range(0, 9) != 0)
        tag_release_tag = TAG_NUM_LOG'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        tag_release_tag = TAG_NUM_LOG'($urandom_range(0, TAG_NUM - 1));
      step();
    end
    tag_release_valid = 1'b0;
    tag_alloc_ready   = 1'b0;

    // Reset mid-run, allocate 20, reset again and check reissue from tag 0.
    async_reset();
    tag_alloc_ready = 1'b1;
    repeat (TAG_NUM + 1 + 20) step();
    tag_alloc_ready = 1'b0;
    step();
    check("busy20", 32'(busy_cnt), 20);
    async_reset();
    tag_alloc_ready = 1'b1;
    repeat (TAG_NUM) step();
    check("init_done_idle", 32'(tag_alloc_valid), 0);
    step();
    check("first_tag", 32'(tag_alloc_tag), 0);
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
